// File: rtl/prco_fetch.sv
// Instruction fetch: single-outstanding reads from local memory into a small instruction FIFO.
// Latency: read issued at N, pushed at the N+1 edge, visible at N+2. Backpressure: i_ready stalls the head; reads stop once count+inflight fills the FIFO.
module prco_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] q_mem_addr,
  output logic        q_mem_re,
  input  logic [15:0] i_mem_dout,
  output logic [15:0] q_instr,
  output logic [15:0] q_instr_pc,
  output logic        q_valid,
  input  logic        i_ready
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [15:0]   pc_q, pc_d;
  logic [15:0]   iss_pc_q, iss_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]   instr_q [FIFO_DEPTH];
  logic [15:0]   ipc_q   [FIFO_DEPTH];
  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;

  assign q_mem_addr = pc_q;
  assign q_instr    = instr_q[rd_ptr_q];
  assign q_instr_pc = ipc_q[rd_ptr_q];

  // The in-flight read reserves a slot, so a pop this cycle cannot free room for a new issue.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    q_mem_re   = i_reset_n & i_en & ~i_redirect & (occupancy < DEPTH_W);
    q_valid    = (count_q != '0) & ~i_redirect;
    push       = inflight_q & ~i_redirect;
    pop        = q_valid & i_ready;

    pc_d       = pc_q;
    iss_pc_d   = iss_pc_q;
    inflight_d = q_mem_re;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      count_d  = '0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (q_mem_re) begin
        pc_d     = pc_q + 16'd1;
        iss_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q       <= RESET_PC;
      iss_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      iss_pc_q   <= iss_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= i_mem_dout;
        ipc_q[wr_ptr_q]   <= iss_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_prco_fetch.sv
// Bench for prco_fetch: directed scenarios plus random traffic against a queue-based fetch model.
module tb_prco_fetch;

  localparam int          D   = 4;
  localparam logic [15:0] RPC = 16'h0000;
  localparam logic [15:0] KEY = 16'hA5A5;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = '0;
  logic [15:0] i_mem_dout = '0;
  logic        i_ready = 1'b0;
  logic [15:0] q_mem_addr;
  logic        q_mem_re;
  logic [15:0] q_instr;
  logic [15:0] q_instr_pc;
  logic        q_valid;

  prco_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_en          (i_en),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .q_mem_addr    (q_mem_addr),
    .q_mem_re      (q_mem_re),
    .i_mem_dout    (i_mem_dout),
    .q_instr       (q_instr),
    .q_instr_pc    (q_instr_pc),
    .q_valid       (q_valid),
    .i_ready       (i_ready)
  );

  always #5 i_clk = ~i_clk;

  // Memory word at address a is a ^ KEY, returned one cycle after the address.
  always @(posedge i_clk) i_mem_dout <= q_mem_addr ^ KEY;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: fetch PC, one pending read, and the FIFO as a queue of addresses.
  logic [15:0] m_fifo[$];
  bit          m_infl = 1'b0;
  logic [15:0] m_infl_pc = '0;
  logic [15:0] m_pc = RPC;

  bit          s_re;
  bit          s_valid;
  logic [15:0] s_ipc;
  logic [15:0] s_addr;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit en, input bit rdy, input bit redir,
                      input logic [15:0] rpc);
    bit e_re;
    bit e_valid;
    @(posedge i_clk);
    #1;
    i_reset_n     = rst_n;
    i_en          = en;
    i_ready       = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    #4;
    s_re    = q_mem_re;
    s_valid = q_valid;
    s_ipc   = q_instr_pc;
    s_addr  = q_mem_addr;
    if (!rst_n) begin
      m_fifo.delete();
      m_infl = 1'b0;
      m_pc   = RPC;
      chk("rst_re",    16'(q_mem_re), 16'd0);
      chk("rst_valid", 16'(q_valid),  16'd0);
      chk("rst_instr", q_instr,       16'h0000);
      chk("rst_ipc",   q_instr_pc,    16'h0000);
      chk("rst_addr",  q_mem_addr,    RPC);
      return;
    end
    e_valid = (m_fifo.size() != 0) && !redir;
    e_re    = en && !redir && ((m_fifo.size() + int'(m_infl)) < D);
    chk("mem_re",   16'(q_mem_re), 16'(e_re));
    chk("valid",    16'(q_valid),  16'(e_valid));
    chk("mem_addr", q_mem_addr,    m_pc);
    if (e_valid) begin
      chk("instr_pc", q_instr_pc, m_fifo[0]);
      chk("instr",    q_instr,    m_fifo[0] ^ KEY);
    end
    if (redir) begin
      m_fifo.delete();
      m_infl = 1'b0;
      m_pc   = rpc;
    end else begin
      if (e_valid && rdy) void'(m_fifo.pop_front());
      if (m_infl) m_fifo.push_back(m_infl_pc);
      m_infl = e_re;
      if (e_re) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 16'd1;
      end
    end
  endtask

  initial begin
    int nreads;
    int got;
    bit seen;

    // Reset and initial streaming
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("r32_first_re",   16'(s_re),    16'd1);
    chk("r32_first_addr", s_addr,       RPC);
    step(1, 1, 1, 0, 0);
    chk("r32_c2_valid",   16'(s_valid), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 0);
      chk("r32_valid", 16'(s_valid), 16'd1);
      chk("r32_pc",    s_ipc,        16'(i));
    end

    // Stalled decoder fills the buffer, then drains without gaps
    step(0, 1, 0, 0, 0);
    nreads = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0);
      nreads += int'(s_re);
    end
    chk("r33_reads",   16'(nreads), 16'd4);
    chk("r33_re_low",  16'(s_re),   16'd0);
    chk("r33_head",    s_ipc,       16'h0000);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0, 0);
      chk("r33_drain_v",  16'(s_valid), 16'd1);
      chk("r33_drain_pc", s_ipc,        16'(i));
    end

    // Redirect with 3 entries buffered and a read in flight
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 16'h0040);
    chk("r34_redir_re", 16'(s_re), 16'd0);
    step(1, 1, 1, 0, 0);
    chk("r34_re",   16'(s_re), 16'd1);
    chk("r34_addr", s_addr,    16'h0040);
    step(1, 1, 1, 0, 0);
    chk("r34_gap",  16'(s_valid), 16'd0);
    step(1, 1, 1, 0, 0);
    chk("r34_v",    16'(s_valid), 16'd1);
    chk("r34_pc",   s_ipc,        16'h0040);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);

    // Redirect near the top of the address space wraps
    step(1, 1, 1, 1, 16'hFFFE);
    got = 0;
    for (int i = 0; i < 10 && got < 4; i++) begin
      step(1, 1, 1, 0, 0);
      if (s_valid) begin
        chk("r35_pc", s_ipc, 16'hFFFE + 16'(got));
        got++;
      end
    end
    chk("r35_count", 16'(got), 16'd4);

    // Enable dropped for one cycle right after an issue
    step(1, 1, 1, 0, 0);
    chk("r36_pre_re", 16'(s_re), 16'd1);
    step(1, 0, 1, 0, 0);
    chk("r36_no_re",  16'(s_re), 16'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);

    // Reset while a read is in flight with two entries buffered
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1, 1, 1, 0, 0);
      if (s_valid) begin
        chk("r37_first_pc", s_ipc, RPC);
        seen = 1'b1;
      end
    end
    chk("r37_seen", 16'(seen), 16'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0),
           16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prco_fetch.md
PRCO_FETCH -- requirements
Module: prco_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of instruction buffer entries (power of two, 2..8).
REQ-003 SHALL have port i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_en  in  1  fetch enable; when low, no new memory reads are issued.
REQ-006 SHALL have port i_redirect  in  1  branch/jump redirect strobe from the core.
REQ-007 SHALL have port i_redirect_pc  in  16  new fetch address, sampled when i_redirect=1.
REQ-008 SHALL have port q_mem_addr  out  16  local-memory read address, equal to the fetch PC.
REQ-009 SHALL have port q_mem_re  out  1  read issued this cycle.
REQ-010 SHALL have port i_mem_dout  in  16  memory read data, valid exactly 1 cycle after q_mem_re.
REQ-011 SHALL have port q_instr  out  16  instruction word at the FIFO head, feeding the decoder.
REQ-012 SHALL have port q_instr_pc  out  16  address of q_instr.
REQ-013 SHALL have port q_valid  out  1  q_instr/q_instr_pc hold a valid entry.
REQ-014 SHALL have port i_ready  in  1  decoder accepts the head entry.

Function
REQ-015 SHALL drive q_mem_re = i_en & ~i_redirect & (count + inflight < FIFO_DEPTH), combinationally; a pop in the same cycle earns no credit.
REQ-016 SHALL increment the fetch PC by 1 on every cycle with q_mem_re=1, wrapping 16'hFFFF -> 16'h0000.
REQ-017 SHALL set inflight=1 in the cycle after q_mem_re=1; otherwise inflight=0. Only one read is outstanding.
REQ-018 SHALL push {i_mem_dout, issue address} into the FIFO when inflight=1 and the read has not been killed.
REQ-019 SHALL pop the head entry when q_valid & i_ready; push and pop in the same cycle leave count unchanged.
REQ-020 SHALL drive q_valid = (count != 0) & ~i_redirect.
REQ-021 SHALL hold q_instr and q_instr_pc stable while q_valid=1 and i_ready=0.
REQ-022 SHALL give priority to i_redirect over every other event in that cycle: FIFO flushed (count=0), any handshake in that cycle discarded, fetch PC loaded from i_redirect_pc, no read issued.
REQ-023 SHALL kill the return of a read issued in the cycle before a redirect, so it is never pushed.
REQ-024 SHALL issue the first read of i_redirect_pc in the cycle after the redirect, if i_en=1.
REQ-025 SHALL have a latency of 2 cycles from issue to visible data: read at cycle N, data at N+1, pushed at the N+1 edge, q_valid at N+2.
REQ-026 SHALL, with i_en low, keep the fetch PC, still capture any in-flight return, and keep serving pops.
REQ-027 SHALL sustain 1 instruction per cycle when i_en=1, i_ready=1, and there are no redirects.
REQ-028 SHALL never overflow; pushes are bounded by REQ-015. Popping an empty FIFO SHALL be impossible (q_valid=0).

Reset
REQ-029 SHALL, on i_reset_n=0 and at any time including mid-read, immediately set: fetch PC=RESET_PC, count=0, inflight=0, q_valid=0, q_instr=16'h0000, q_instr_pc=16'h0000.
REQ-030 SHALL discard any read outstanding at reset; q_mem_re SHALL be 0 while in reset.
REQ-031 SHALL issue the first read at the first rising edge after i_reset_n rises, provided i_en=1.

Verification
REQ-032 Reset release, i_en=1, i_ready=1, memory word = address XOR 16'hA5A5 -> q_valid rises 2 cycles after the first read; q_instr_pc sequence 0,1,2,3 on consecutive cycles; q_instr 16'hA5A5, 16'hA5A4, ...
REQ-033 i_ready=0 for 10 cycles -> exactly 4 reads issued, q_mem_re low afterwards, head stays at pc 0; i_ready=1 -> entries 0..3 drain in order with no gaps, and fetching resumes at pc 4.
REQ-034 Redirect to 16'h0040 while the FIFO holds 3 entries and a read is in flight -> no entry with pc < 16'h0040 appears afterwards; the first valid q_instr_pc is 16'h0040, 2 cycles after the redirect's following cycle.
REQ-035 Redirect to 16'hFFFE with i_ready=1 -> q_instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-036 i_en dropped for one cycle right after a read issues -> the return is still pushed; no read occurs in the disabled cycle; the PC sequence has no gap or duplicate.
REQ-037 i_reset_n asserted while inflight=1 and count=2 -> all outputs reach reset values that same cycle; after release the first q_instr_pc is RESET_PC.
